// File: rtl/jtag_ram_pkg.sv
// Shared definitions for the parametrised scan RAM.
// Holds the address-width helper, byte-lane helpers and the parameter legality
// predicates used by jtag_ram_param and jtag_word.
package jtag_ram_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 64;
    // Byte-lane count of the default word; per-instance value comes from lanes().
    localparam int unsigned BYTES     = DEF_WIDTH / BYTE_W;

    // Ceiling log2, minimum result 1 so a 2-word RAM still has an address bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned lanes(input int unsigned width);
        return width / BYTE_W;
    endfunction

    function automatic bit width_ok(input int unsigned width);
        return (width != 0) && ((width % BYTE_W) == 0);
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && (depth <= 1024) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/jtag_word.sv
// One RAM word: WIDTH-bit register with async clear.
// Next state: scan-in (highest priority), byte-masked write, or hold.
// Ports: clk, rst_n, scan_en_i/scan_d_i (chain), wr_en_i/ben_i/din_i (write), q_o.
module jtag_word
    import jtag_ram_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scan_en_i,
    input  logic [WIDTH-1:0]         scan_d_i,
    input  logic                     wr_en_i,
    input  logic [lanes(WIDTH)-1:0]  ben_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         q_o
);

    localparam int unsigned NB = lanes(WIDTH);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Next-state select.
    always_comb begin
        word_d = word_q;
        if (scan_en_i) begin
            word_d = scan_d_i;
        end else if (wr_en_i) begin
            for (int k = 0; k < int'(NB); k++) begin
                if (ben_i[k]) word_d[k*BYTE_W +: BYTE_W] = din_i[k*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_q <= '0;
        else        word_q <= word_d;
    end

    assign q_o = word_q;

endmodule

// File: rtl/jtag_ram_param.sv
// Parametrised flop RAM with functional R/W port and word-serial scan chain.
// Ports: clk, rst_n; Addr/Din/Ben/Wen/Dout functional port; Jen/Jin/Jout scan
// chain (enters at word 0, exits at word DEPTH-1); Jcnt shift count, Jdone
// full-rotation pulse, Wdrop pulse for a write discarded by a scan shift.
module jtag_ram_param
    import jtag_ram_pkg::*;
#(
    parameter  int unsigned WIDTH   = DEF_WIDTH,
    parameter  int unsigned DEPTH   = DEF_DEPTH,
    parameter  int unsigned REG_OUT = 0,
    localparam int unsigned AW      = clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [AW-1:0]            Addr,
    input  logic [WIDTH-1:0]         Din,
    input  logic [lanes(WIDTH)-1:0]  Ben,
    input  logic                     Wen,
    output logic [WIDTH-1:0]         Dout,
    input  logic                     Jen,
    input  logic [WIDTH-1:0]         Jin,
    output logic [WIDTH-1:0]         Jout,
    output logic [AW-1:0]            Jcnt,
    output logic                     Jdone,
    output logic                     Wdrop
);

    if (!width_ok(WIDTH) || !depth_ok(DEPTH)) begin : g_bad_params
        $error("jtag_ram_param: WIDTH must be a multiple of 8 and DEPTH a power of two in 2..1024");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ok_c;
    logic [WIDTH-1:0] rd_data_c;

    // Scan always wins over a functional write.
    assign wr_ok_c = Wen & ~Jen;

    // Word array; each word's scan input is its predecessor, word 0 takes Jin.
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_word
        logic [WIDTH-1:0] scan_d_c;
        logic             sel_c;

        if (g == 0) begin : g_head
            assign scan_d_c = Jin;
        end else begin : g_body
            assign scan_d_c = mem_q[g-1];
        end

        assign sel_c = wr_ok_c && (Addr == AW'(g));

        jtag_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk       (clk),
            .rst_n     (rst_n),
            .scan_en_i (Jen),
            .scan_d_i  (scan_d_c),
            .wr_en_i   (sel_c),
            .ben_i     (Ben),
            .din_i     (Din),
            .q_o       (mem_q[g])
        );
    end

    assign rd_data_c = mem_q[Addr];
    assign Jout      = mem_q[DEPTH-1];

    // Read path: registered copy samples pre-edge contents, also during scan.
    if (REG_OUT != 0) begin : g_reg_out
        logic [WIDTH-1:0] dout_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dout_q <= '0;
            else        dout_q <= rd_data_c;
        end
        assign Dout = dout_q;
    end else begin : g_comb_out
        assign Dout = rd_data_c;
    end

    // Scan-position counter, rotation pulse and dropped-write pulse.
    logic [AW-1:0] jcnt_q, jcnt_d;
    logic          jdone_q, jdone_d;
    logic          wdrop_q, wdrop_d;

    always_comb begin
        jcnt_d  = jcnt_q;
        jdone_d = 1'b0;
        wdrop_d = Wen & Jen;
        if (Jen) begin
            jcnt_d  = jcnt_q + AW'(1);
            jdone_d = (jcnt_q == AW'(DEPTH - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jcnt_q  <= '0;
            jdone_q <= 1'b0;
            wdrop_q <= 1'b0;
        end else begin
            jcnt_q  <= jcnt_d;
            jdone_q <= jdone_d;
            wdrop_q <= wdrop_d;
        end
    end

    assign Jcnt  = jcnt_q;
    assign Jdone = jdone_q;
    assign Wdrop = wdrop_q;

endmodule

// File: tb/tb_jtag_ram_param.sv
// Directed bench for jtag_ram_param: instance A is 32x64 combinational read,
// instance B is 16x8 registered read.
module tb_jtag_ram_param;

    logic clk;
    logic rst_n;

    logic [5:0]  addr_a;
    logic [31:0] din_a, jin_a, dout_a, jout_a;
    logic [3:0]  ben_a;
    logic        wen_a, jen_a, jdone_a, wdrop_a;
    logic [5:0]  jcnt_a;

    logic [2:0]  addr_b;
    logic [15:0] din_b, jin_b, dout_b, jout_b;
    logic [1:0]  ben_b;
    logic        wen_b, jen_b, jdone_b, wdrop_b;
    logic [2:0]  jcnt_b;

    int n_checks;
    int n_fail;

    jtag_ram_param #(.WIDTH(32), .DEPTH(64), .REG_OUT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .Addr(addr_a), .Din(din_a), .Ben(ben_a),
        .Wen(wen_a), .Dout(dout_a), .Jen(jen_a), .Jin(jin_a), .Jout(jout_a),
        .Jcnt(jcnt_a), .Jdone(jdone_a), .Wdrop(wdrop_a)
    );

    jtag_ram_param #(.WIDTH(16), .DEPTH(8), .REG_OUT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .Addr(addr_b), .Din(din_b), .Ben(ben_b),
        .Wen(wen_b), .Dout(dout_b), .Jen(jen_b), .Jin(jin_b), .Jout(jout_b),
        .Jcnt(jcnt_b), .Jdone(jdone_b), .Wdrop(wdrop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (jcnt_a !== 6'd0 || jdone_a !== 1'b0 || wdrop_a !== 1'b0 || jout_a !== 32'd0 || dout_a !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_a: jcnt=%0d jdone=%b wdrop=%b jout=%h dout=%h, required all 0", jcnt_a, jdone_a, wdrop_a, jout_a, dout_a);
        end
        n_checks++;
        if (jcnt_b !== 3'd0 || jdone_b !== 1'b0 || wdrop_b !== 1'b0 || jout_b !== 16'd0 || dout_b !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_b: jcnt=%0d jdone=%b wdrop=%b jout=%h dout=%h, required all 0", jcnt_b, jdone_b, wdrop_b, jout_b, dout_b);
        end
        step();
        rst_n = 1'b1;
        step();
        // Fill both chains, then reset while still shifting.
        for (int i = 0; i < 69; i++) begin
            jen_a = 1'b1; jin_a = 32'(i + 1);
            jen_b = 1'b1; jin_b = 16'(i + 1);
            step();
        end
        n_checks++;
        if (jcnt_a !== 6'd5 || jcnt_b !== 3'd5) begin
            n_fail++;
            $display("FAIL prefill_jcnt: a=%0d b=%0d, required 5 and 5", jcnt_a, jcnt_b);
        end
        n_checks++;
        if (jout_a === 32'd0) begin
            n_fail++;
            $display("FAIL prefill_jout: jout_a=%h, required nonzero", jout_a);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (jcnt_a !== 6'd0 || jout_a !== 32'd0 || jcnt_b !== 3'd0 || jout_b !== 16'd0 || dout_b !== 16'd0) begin
            n_fail++;
            $display("FAIL midscan_reset: jcnt_a=%0d jout_a=%h jcnt_b=%0d jout_b=%h dout_b=%h, required 0", jcnt_a, jout_a, jcnt_b, jout_b, dout_b);
        end
        for (int a = 0; a < 64; a++) begin
            addr_a = 6'(a);
            #1;
            n_checks++;
            if (dout_a !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_mem addr=%0d: got %h, required 00000000", a, dout_a);
            end
        end
        jen_a = 1'b0; jin_a = '0;
        jen_b = 1'b0; jin_b = '0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_byte_write();
        addr_a = 6'd5; din_a = 32'h1122_3344; ben_a = 4'hF; wen_a = 1'b1;
        step();
        n_checks++;
        if (dout_a !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL full_write: got %h, required 11223344", dout_a);
        end
        din_a = 32'hAABB_CCDD; ben_a = 4'b0101;
        step();
        wen_a = 1'b0;
        #1;
        n_checks++;
        if (dout_a !== 32'h11BB_33DD) begin
            n_fail++;
            $display("FAIL lane_write: got %h, required 11BB33DD", dout_a);
        end
        n_checks++;
        if (wdrop_a !== 1'b0) begin
            n_fail++;
            $display("FAIL lane_write_wdrop: got %b, required 0", wdrop_a);
        end
        addr_a = 6'd4;
        #1;
        n_checks++;
        if (dout_a !== 32'd0) begin
            n_fail++;
            $display("FAIL neighbour_word: got %h, required 00000000", dout_a);
        end
    endtask

    task automatic test_scan_load_dump();
        for (int s = 1; s <= 128; s++) begin
            jen_a = 1'b1;
            jin_a = (s <= 64) ? 32'(s - 1) : 32'd0;
            step();
            n_checks++;
            if (jcnt_a !== 6'(s % 64)) begin
                n_fail++;
                $display("FAIL scan_jcnt shift=%0d: got %0d, required %0d", s, jcnt_a, s % 64);
            end
            n_checks++;
            if (jdone_a !== ((s == 64) || (s == 128))) begin
                n_fail++;
                $display("FAIL scan_jdone shift=%0d: got %b, required %b", s, jdone_a, (s == 64) || (s == 128));
            end
            if (s >= 64 && s <= 127) begin
                n_checks++;
                if (jout_a !== 32'(s - 64)) begin
                    n_fail++;
                    $display("FAIL scan_jout shift=%0d: got %h, required %h", s, jout_a, 32'(s - 64));
                end
            end
        end
        jen_a = 1'b0;
        step();
        n_checks++;
        if (jcnt_a !== 6'd0 || jdone_a !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_idle: jcnt=%0d jdone=%b, required 0 and 0", jcnt_a, jdone_a);
        end
    endtask

    task automatic test_scan_consistency();
        for (int i = 0; i < 64; i++) begin
            jen_a = 1'b1; jin_a = 32'(i);
            step();
        end
        jen_a = 1'b0;
        for (int a = 0; a < 64; a++) begin
            addr_a = 6'(a);
            #1;
            n_checks++;
            if (dout_a !== 32'(63 - a)) begin
                n_fail++;
                $display("FAIL scan_read addr=%0d: got %h, required %h", a, dout_a, 32'(63 - a));
            end
        end
    endtask

    task automatic test_collision();
        addr_a = 6'd3; din_a = 32'hFFFF_FFFF; ben_a = 4'hF; wen_a = 1'b1;
        jen_a = 1'b1; jin_a = 32'h1234_5678;
        step();
        wen_a = 1'b0; jen_a = 1'b0;
        #1;
        n_checks++;
        if (wdrop_a !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_wdrop: got %b, required 1", wdrop_a);
        end
        n_checks++;
        if (dout_a !== 32'd61) begin
            n_fail++;
            $display("FAIL collision_word3: got %h, required 0000003d", dout_a);
        end
        n_checks++;
        if (jcnt_a !== 6'd1) begin
            n_fail++;
            $display("FAIL collision_jcnt: got %0d, required 1", jcnt_a);
        end
        addr_a = 6'd0;
        #1;
        n_checks++;
        if (dout_a !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL collision_shift: got %h, required 12345678", dout_a);
        end
        step();
        n_checks++;
        if (wdrop_a !== 1'b0) begin
            n_fail++;
            $display("FAIL wdrop_one_cycle: got %b, required 0", wdrop_a);
        end
        // Write with no lanes enabled.
        addr_a = 6'd3; din_a = 32'hFFFF_FFFF; ben_a = 4'h0; wen_a = 1'b1;
        step();
        wen_a = 1'b0;
        #1;
        n_checks++;
        if (dout_a !== 32'd61 || wdrop_a !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_ben: dout=%h wdrop=%b, required 0000003d and 0", dout_a, wdrop_a);
        end
    endtask

    task automatic test_param_b();
        addr_b = 3'd5; din_b = 16'h1122; ben_b = 2'b11; wen_b = 1'b1;
        step();
        din_b = 16'hAABB; ben_b = 2'b01;
        step();
        wen_b = 1'b0;
        #1;
        n_checks++;
        if (dout_b !== 16'h1122) begin
            n_fail++;
            $display("FAIL b_read_before_write: got %h, required 1122", dout_b);
        end
        addr_b = 3'd4;
        step();
        n_checks++;
        if (dout_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL b_addr4: got %h, required 0000", dout_b);
        end
        addr_b = 3'd5;
        #1;
        n_checks++;
        if (dout_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL b_reg_latency: got %h, required 0000", dout_b);
        end
        step();
        n_checks++;
        if (dout_b !== 16'h11BB) begin
            n_fail++;
            $display("FAIL b_lane_write: got %h, required 11bb", dout_b);
        end
        for (int s = 1; s <= 16; s++) begin
            jen_b = 1'b1;
            jin_b = (s <= 8) ? 16'(s - 1) : 16'd0;
            step();
            n_checks++;
            if (jcnt_b !== 3'(s % 8)) begin
                n_fail++;
                $display("FAIL b_jcnt shift=%0d: got %0d, required %0d", s, jcnt_b, s % 8);
            end
            n_checks++;
            if (jdone_b !== ((s == 8) || (s == 16))) begin
                n_fail++;
                $display("FAIL b_jdone shift=%0d: got %b, required %b", s, jdone_b, (s == 8) || (s == 16));
            end
            if (s >= 8 && s <= 15) begin
                n_checks++;
                if (jout_b !== 16'(s - 8)) begin
                    n_fail++;
                    $display("FAIL b_jout shift=%0d: got %h, required %h", s, jout_b, 16'(s - 8));
                end
            end
        end
        jen_b = 1'b0;
        step();
        n_checks++;
        if (jcnt_b !== 3'd0 || jdone_b !== 1'b0) begin
            n_fail++;
            $display("FAIL b_idle: jcnt=%0d jdone=%b, required 0 and 0", jcnt_b, jdone_b);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n  = 1'b0;
        addr_a = '0; din_a = '0; ben_a = '0; wen_a = 1'b0; jen_a = 1'b0; jin_a = '0;
        addr_b = '0; din_b = '0; ben_b = '0; wen_b = 1'b0; jen_b = 1'b0; jin_b = '0;
        test_reset();
        test_byte_write();
        test_scan_load_dump();
        test_scan_consistency();
        test_collision();
        test_param_b();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
